// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector memory sequencer.
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  typedef enum logic {
    VOP_LOAD  = 1'b0,
    VOP_STORE = 1'b1
  } vec_op_t;

  localparam int VEC_LANES = 4;
  localparam int VEC_ARQ   = 32;

  // Bit position of the least significant bit of a lane inside a packed vector.
  function automatic int lane_lsb(input int lane, input int arq);
    return lane * arq;
  endfunction

endpackage

// File: rtl/vector_mem_sequencer.sv
// Multi-cycle sequencer for vector load/store on a single-port, one-word-per-access
// data memory. Walks LANES consecutive words, stalls the pipeline while busy and
// pulses vec_load_we when a loaded vector is complete.
module vector_mem_sequencer
  import vec_pkg::*;
#(
  parameter int ARQ    = VEC_ARQ,
  parameter int LANES  = VEC_LANES,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r_mem,
  input  logic                  w_mem,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LANES*ARQ-1:0]  wr_vec,
  output logic [LANES*ARQ-1:0]  rd_vec,
  output logic                  vec_load_we,
  output logic                  stall,
  output logic                  busy,
  output logic                  req_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [ARQ-1:0]        mem_wdata,
  input  logic [ARQ-1:0]        mem_rdata,
  input  logic                  mem_ack
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  seq_state_t             state, state_nxt;
  vec_op_t                op_p0;
  logic [LANE_W-1:0]      lane;
  logic [ADDR_W-1:0]      base_p0;
  logic [LANES*ARQ-1:0]   vec_p0;
  logic                   accept;
  logic                   lane_done;

  assign busy      = (state != IDLE);
  assign lane_done = (state == ACCESS) && mem_ack;

  // Control state: FSM register, latched operation and lane counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_p0 <= VOP_LOAD;
      lane  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_p0 <= w_mem ? VOP_STORE : VOP_LOAD;
        lane  <= '0;
      end else if (lane_done) begin
        lane  <= lane + LANE_W'(1);
      end
    end
  end

  // Request operands captured on accept; later input changes cannot disturb a transfer.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_p0 <= base_addr;
      vec_p0  <= wr_vec;
    end
  end

  // Assemble the loaded vector one lane per acknowledged read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vec <= '0;
    end else if (lane_done && (op_p0 == VOP_LOAD)) begin
      rd_vec[lane_lsb(int'(lane), ARQ) +: ARQ] <= mem_rdata;
    end
  end

  // Next-state and output decode; the request cycle itself stalls combinationally.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    stall       = 1'b0;
    req_err     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    vec_load_we = 1'b0;
    case (state)
      IDLE: begin
        if (r_mem ^ w_mem) begin
          accept    = 1'b1;
          stall     = 1'b1;
          state_nxt = ACCESS;
        end else if (r_mem && w_mem) begin
          req_err = 1'b1;
        end
      end
      ACCESS: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = (op_p0 == VOP_STORE);
        mem_addr  = base_p0 + ADDR_W'(lane) * ADDR_W'(ARQ / 8);
        mem_wdata = vec_p0[lane_lsb(int'(lane), ARQ) +: ARQ];
        if (mem_ack && (lane == LAST_LANE)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        vec_load_we = (op_p0 == VOP_LOAD);
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Randomized self-checking bench for vector_mem_sequencer with a word-addressed
// memory model and per-transaction expectations computed from the transfer rules.
module tb_vector_mem_sequencer;

  localparam int ARQ    = 32;
  localparam int LANES  = 4;
  localparam int ADDR_W = 32;
  localparam int VW     = LANES * ARQ;
  localparam int CW     = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              r_mem, w_mem;
  logic [ADDR_W-1:0] base_addr;
  logic [VW-1:0]     wr_vec;
  logic [VW-1:0]     rd_vec;
  logic              vec_load_we, stall, busy, req_err;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ARQ-1:0]    mem_wdata, mem_rdata;
  logic              mem_ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];

  vector_mem_sequencer #(.ARQ(ARQ), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .r_mem(r_mem), .w_mem(w_mem),
    .base_addr(base_addr), .wr_vec(wr_vec), .rd_vec(rd_vec),
    .vec_load_we(vec_load_we), .stall(stall), .busy(busy), .req_err(req_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   CW'(mem_req), '0);
    chk({tag, "_we"},    CW'(mem_we), '0);
    chk({tag, "_addr"},  CW'(mem_addr), '0);
    chk({tag, "_wdata"}, CW'(mem_wdata), '0);
    chk({tag, "_stall"}, CW'(stall), '0);
    chk({tag, "_busy"},  CW'(busy), '0);
    chk({tag, "_err"},   CW'(req_err), '0);
    chk({tag, "_vld"},   CW'(vec_load_we), '0);
    chk({tag, "_rdvec"}, CW'(rd_vec), '0);
  endtask

  // One complete vector transfer; abort_lane >= 0 pulls reset during that lane.
  task automatic do_xfer(input bit is_load, input logic [31:0] base, input logic [VW-1:0] wv,
                         input int minw, input int maxw, input bit hold, input int abort_lane);
    int          stall_cnt;
    int          exp_stall;
    int          w;
    logic [VW-1:0] exp_rd;
    logic [31:0] a;
    stall_cnt = 0;
    exp_stall = 1;
    exp_rd    = '0;
    @(negedge clk);
    r_mem = is_load; w_mem = !is_load;
    base_addr = base; wr_vec = wv;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    chk("acc_stall", CW'(stall), CW'(1));
    chk("acc_busy",  CW'(busy), '0);
    chk("acc_req",   CW'(mem_req), '0);
    chk("acc_err",   CW'(req_err), '0);
    stall_cnt += int'(stall);
    for (int i = 0; i < LANES; i++) begin
      w = $urandom_range(minw, maxw);
      a = base + 32'(i * 4);
      exp_stall += w + 1;
      for (int c = 0; c <= w; c++) begin
        @(negedge clk);
        if (!hold) begin r_mem = 1'b0; w_mem = 1'b0; end
        base_addr = $urandom;
        wr_vec    = {$urandom, $urandom, $urandom, $urandom};
        mem_ack   = (c == w);
        mem_rdata = (c == w) ? rd_word(a) : $urandom;
        #1;
        chk("req",  CW'(mem_req), CW'(1));
        chk("we",   CW'(mem_we), CW'(!is_load));
        chk("addr", CW'(mem_addr), CW'(a));
        if (!is_load) chk("wdata", CW'(mem_wdata), CW'(wv[i*32 +: 32]));
        chk("busy", CW'(busy), CW'(1));
        stall_cnt += int'(stall);
        if (i == abort_lane) begin
          r_mem = 1'b0; w_mem = 1'b0;
          rst_n = 1'b0;
          #1;
          chk_all_zero("rst_mid");
          @(negedge clk);
          mem_ack = 1'b0;
          rst_n = 1'b1;
          return;
        end
        if (c == w) begin
          if (is_load) exp_rd[i*32 +: 32] = rd_word(a);
          else mem[a] = wv[i*32 +: 32];
        end
      end
    end
    @(negedge clk);
    if (!hold) begin r_mem = 1'b0; w_mem = 1'b0; end
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    chk("done_req",   CW'(mem_req), '0);
    chk("done_stall", CW'(stall), '0);
    chk("done_busy",  CW'(busy), CW'(1));
    chk("done_vld",   CW'(vec_load_we), CW'(is_load));
    if (is_load) chk("done_rdvec", CW'(rd_vec), CW'(exp_rd));
    stall_cnt += int'(stall);
    chk("stall_cycles", CW'(stall_cnt), CW'(exp_stall));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      r_mem = 1'b0; w_mem = 1'b0; mem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("idle_busy", CW'(busy), '0);
      chk("idle_req",  CW'(mem_req), '0);
    end
  endtask

  initial begin
    logic [VW-1:0] v;
    rst_n = 1'b0; r_mem = 1'b0; w_mem = 1'b0; base_addr = '0; wr_vec = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Load, zero wait, known data.
    for (int i = 0; i < LANES; i++) mem[32'h100 + 32'(i * 4)] = 32'hA0 + 32'(i);
    do_xfer(1'b1, 32'h100, '0, 0, 0, 1'b0, -1);
    idle_cycles(1);
    chk("t1_rdvec", CW'(rd_vec), 128'h000000A3_000000A2_000000A1_000000A0);

    // Store with two wait cycles per lane.
    do_xfer(1'b0, 32'h20, 128'h00000004_00000003_00000002_00000001, 2, 2, 1'b0, -1);
    idle_cycles(1);
    chk("t2_m20", CW'(mem[32'h20]), CW'(32'h1));
    chk("t2_m2c", CW'(mem[32'h2C]), CW'(32'h4));

    // Both requests high: rejected.
    @(negedge clk);
    r_mem = 1'b1; w_mem = 1'b1; mem_ack = 1'b0;
    #1;
    chk("t3_err",   CW'(req_err), CW'(1));
    chk("t3_req",   CW'(mem_req), '0);
    chk("t3_stall", CW'(stall), '0);
    idle_cycles(1);
    chk("t3_err_gone", CW'(req_err), '0);

    // Address wrap at top of memory.
    do_xfer(1'b1, 32'hFFFF_FFF8, '0, 0, 1, 1'b0, -1);
    idle_cycles(1);

    // Reset during lane 2 of a store, then a fresh load starts at lane 0.
    do_xfer(1'b0, 32'h300, {$urandom, $urandom, $urandom, $urandom}, 0, 2, 1'b0, 2);
    do_xfer(1'b1, 32'h40, '0, 0, 1, 1'b0, -1);
    idle_cycles(1);

    // Back-to-back load (request held through DONE) then store.
    v = {$urandom, $urandom, $urandom, $urandom};
    do_xfer(1'b1, 32'h500, '0, 0, 1, 1'b1, -1);
    do_xfer(1'b0, 32'h500, v, 0, 1, 1'b0, -1);
    idle_cycles(1);
    do_xfer(1'b1, 32'h500, '0, 0, 0, 1'b0, -1);
    chk("t6_rdback", CW'(rd_vec), CW'(v));
    idle_cycles(1);

    // Randomized mix over a small address window so loads revisit stores.
    for (int t = 0; t < 40; t++) begin
      bit ld;
      bit hd;
      ld = 1'($urandom_range(0, 1));
      hd = (t != 39) && ($urandom_range(0, 3) == 0);
      do_xfer(ld, 32'h1000 + 32'($urandom_range(0, 15) * 4),
              {$urandom, $urandom, $urandom, $urandom}, 0, 3, hd, -1);
      if (!hd) idle_cycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
